// File: rtl/game_controller.sv
`default_nettype none
// ============================================================================
//  Module   : game_controller
//  Purpose  : Player-movement sequencer feeding the image renderer. Turns
//             one-cycle key-edge pulses into a committed direction (with a
//             no-reverse rule), steps the player once per game tick, detects
//             wall collisions and runs the IDLE/PLAYING/PAUSED/DEAD state
//             machine.
//  Ports    : clk        - system clock
//             rst        - asynchronous active-low reset
//             edge_key   - one-cycle key pulses, [3]=R [2]=D [1]=U [0]=L
//             pause      - one-cycle pause/resume pulse
//             game_tick  - one-cycle movement strobe
//             game_state - 0=IDLE 1=PLAYING 2=PAUSED 3=DEAD
//             direction  - committed direction, 0=none 1=R 2=D 4=U 8=L
//             playerX    - player left edge, pixels
//             playerY    - player top edge, pixels
//             score      - ticks survived, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module game_controller #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int PLAYER_SIZE = 20,
   parameter int STEP        = 5,
   parameter int START_X     = 310,
   parameter int START_Y     = 230,
   parameter int DEAD_HOLD   = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  edge_key,
   input  logic        pause,
   input  logic        game_tick,
   output logic [3:0]  game_state,
   output logic [3:0]  direction,
   output logic [15:0] playerX,
   output logic [15:0] playerY,
   output logic [15:0] score
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_PLAYING = 4'd1,
      S_PAUSED  = 4'd2,
      S_DEAD    = 4'd3
   } state_t;

   localparam logic [3:0] c_DIR_NONE = 4'd0;
   localparam logic [3:0] c_DIR_R    = 4'd1;
   localparam logic [3:0] c_DIR_D    = 4'd2;
   localparam logic [3:0] c_DIR_U    = 4'd4;
   localparam logic [3:0] c_DIR_L    = 4'd8;

   localparam logic [15:0] c_START_X = 16'(START_X);
   localparam logic [15:0] c_START_Y = 16'(START_Y);

   // Position arithmetic is done in signed 17-bit so that a step left/up
   // from a coordinate below STEP goes negative instead of wrapping.
   localparam logic signed [16:0] c_STEP  = 17'(STEP);
   localparam logic signed [16:0] c_X_MAX = 17'(SCREEN_W - PLAYER_SIZE);
   localparam logic signed [16:0] c_Y_MAX = 17'(SCREEN_H - PLAYER_SIZE);

   localparam int HOLD_W = (DEAD_HOLD > 1) ? $clog2(DEAD_HOLD) : 1;
   localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(DEAD_HOLD - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [3:0]          dir_q, dir_d;
   logic [3:0]          pend_q, pend_d;
   logic [15:0]         x_q, x_d;
   logic [15:0]         y_q, y_d;
   logic [15:0]         score_q, score_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;

   // One-hot direction codes are mirror images of their opposites
   // (R=0001 <-> L=1000, D=0010 <-> U=0100), so a bit reversal gives
   // the reverse direction; "none" maps to itself.
   function automatic logic [3:0] f_opposite(input logic [3:0] d);
      return {d[0], d[1], d[2], d[3]};
   endfunction

   // ------------------------------------------------------------------------
   // Key arbitration: R > D > L > U
   // ------------------------------------------------------------------------
   logic [3:0] key_win;
   logic [3:0] ref_dir;
   logic       key_ok;

   always_comb begin
      key_win = c_DIR_NONE;
      if (edge_key[3]) begin
         key_win = c_DIR_R;
      end else if (edge_key[2]) begin
         key_win = c_DIR_D;
      end else if (edge_key[0]) begin
         key_win = c_DIR_L;
      end else if (edge_key[1]) begin
         key_win = c_DIR_U;
      end
   end

   // On a tick the pending direction is about to be committed, so a new key
   // must be judged against it rather than the direction currently shown.
   assign ref_dir = game_tick ? pend_q : dir_q;
   assign key_ok  = (|edge_key) && (key_win != f_opposite(ref_dir));

   // ------------------------------------------------------------------------
   // Next-position evaluation (uses the direction being committed)
   // ------------------------------------------------------------------------
   logic signed [16:0] nx;
   logic signed [16:0] ny;
   logic               next_legal;

   always_comb begin
      nx = $signed({1'b0, x_q});
      ny = $signed({1'b0, y_q});
      case (pend_q)
         c_DIR_R: nx = $signed({1'b0, x_q}) + c_STEP;
         c_DIR_L: nx = $signed({1'b0, x_q}) - c_STEP;
         c_DIR_D: ny = $signed({1'b0, y_q}) + c_STEP;
         c_DIR_U: ny = $signed({1'b0, y_q}) - c_STEP;
         default: ;
      endcase
   end

   assign next_legal = (nx >= 17'sd0) && (nx <= c_X_MAX) &&
                       (ny >= 17'sd0) && (ny <= c_Y_MAX);

   // ------------------------------------------------------------------------
   // Game-state FSM: next-state and datapath updates
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      pend_d  = pend_q;
      x_d     = x_q;
      y_d     = y_q;
      score_d = score_q;
      hold_d  = hold_q;

      unique case (state_q)
         S_IDLE: begin
            x_d = c_START_X;
            y_d = c_START_Y;
            if (|edge_key) begin
               // First key starts the game without a reverse check.
               state_d = S_PLAYING;
               dir_d   = key_win;
               pend_d  = key_win;
               score_d = '0;
            end
         end

         S_PLAYING: begin
            if (key_ok) begin
               pend_d = key_win;
            end
            if (pause) begin
               // Pause beats a coincident tick: no commit, no move.
               state_d = S_PAUSED;
            end else if (game_tick) begin
               dir_d = pend_q;
               if (next_legal) begin
                  x_d = nx[15:0];
                  y_d = ny[15:0];
                  if (score_q != 16'hFFFF) begin
                     score_d = score_q + 16'd1;
                  end
               end else begin
                  state_d = S_DEAD;
                  hold_d  = '0;
               end
            end
         end

         S_PAUSED: begin
            if (pause) begin
               state_d = S_PLAYING;
            end
         end

         S_DEAD: begin
            if (game_tick) begin
               if (hold_q == c_HOLD_LAST) begin
                  // Score is left visible until the next game starts.
                  state_d = S_IDLE;
                  x_d     = c_START_X;
                  y_d     = c_START_Y;
                  dir_d   = c_DIR_NONE;
                  pend_d  = c_DIR_NONE;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         dir_q   <= c_DIR_NONE;
         pend_q  <= c_DIR_NONE;
         x_q     <= c_START_X;
         y_q     <= c_START_Y;
         score_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         pend_q  <= pend_d;
         x_q     <= x_d;
         y_q     <= y_d;
         score_q <= score_d;
         hold_q  <= hold_d;
      end
   end

   assign game_state = state_q;
   assign direction  = dir_q;
   assign playerX    = x_q;
   assign playerY    = y_q;
   assign score      = score_q;

endmodule
`default_nettype wire

// File: tb/tb_game_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_controller
//  Purpose  : Self-checking bench for game_controller. A behavioural model
//             predicts the outputs for every driven cycle; predictions are
//             queued and compared once the DUT has registered the cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_game_controller;

   logic        clk;
   logic        rst;
   logic [3:0]  edge_key;
   logic        pause;
   logic        game_tick;
   logic [3:0]  game_state;
   logic [3:0]  direction;
   logic [15:0] playerX;
   logic [15:0] playerY;
   logic [15:0] score;

   int n_vec;
   int n_bad;

   game_controller dut (
      .clk        (clk),
      .rst        (rst),
      .edge_key   (edge_key),
      .pause      (pause),
      .game_tick  (game_tick),
      .game_state (game_state),
      .direction  (direction),
      .playerX    (playerX),
      .playerY    (playerY),
      .score      (score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   int m_state, m_dir, m_pend, m_x, m_y, m_score, m_hold;

   typedef struct {
      logic [3:0]  st;
      logic [3:0]  dir;
      logic [15:0] x;
      logic [15:0] y;
      logic [15:0] sc;
   } exp_t;

   exp_t exp_q[$];

   function automatic int win(input logic [3:0] k);
      if (k[3]) return 1;
      if (k[2]) return 2;
      if (k[0]) return 8;
      if (k[1]) return 4;
      return 0;
   endfunction

   function automatic int opp(input int d);
      case (d)
         1:       return 8;
         8:       return 1;
         2:       return 4;
         4:       return 2;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_state = 0; m_dir = 0; m_pend = 0;
      m_x = 310; m_y = 230; m_score = 0; m_hold = 0;
   endtask

   task automatic model_step(input logic [3:0] k, input logic p, input logic t);
      int w, r, op, nx, ny;
      w = win(k);
      case (m_state)
         0: begin
            if (k != 4'd0) begin
               m_dir = w; m_pend = w; m_score = 0; m_state = 1;
            end
         end
         1: begin
            r  = t ? m_pend : m_dir;
            op = m_pend;
            if (k != 4'd0 && w != opp(r)) m_pend = w;
            if (p) begin
               m_state = 2;
            end else if (t) begin
               m_dir = op;
               nx = m_x; ny = m_y;
               case (op)
                  1: nx = m_x + 5;
                  8: nx = m_x - 5;
                  2: ny = m_y + 5;
                  4: ny = m_y - 5;
                  default: ;
               endcase
               if (nx >= 0 && nx <= 620 && ny >= 0 && ny <= 460) begin
                  m_x = nx; m_y = ny;
                  if (m_score < 65535) m_score = m_score + 1;
               end else begin
                  m_state = 3; m_hold = 0;
               end
            end
         end
         2: begin
            if (p) m_state = 1;
         end
         3: begin
            if (t) begin
               if (m_hold == 49) begin
                  m_state = 0; m_x = 310; m_y = 230;
                  m_dir = 0; m_pend = 0; m_hold = 0;
               end else begin
                  m_hold = m_hold + 1;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic push_exp();
      exp_t e;
      e.st  = 4'(m_state);
      e.dir = 4'(m_dir);
      e.x   = 16'(m_x);
      e.y   = 16'(m_y);
      e.sc  = 16'(m_score);
      exp_q.push_back(e);
   endtask

   // ------------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------------
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
      n_vec++;
      if (got !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, expv, $time);
      end
   endtask

   task automatic sb_pop(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         check({tag, ".state"}, 16'(game_state), 16'(e.st));
         check({tag, ".dir"},   16'(direction),  16'(e.dir));
         check({tag, ".x"},     playerX,         e.x);
         check({tag, ".y"},     playerY,         e.y);
         check({tag, ".score"}, score,           e.sc);
      end
   endtask

   // One clock of stimulus: drive at the falling edge, sample 1 time unit
   // after the rising edge.
   task automatic cycle(input string tag, input logic [3:0] k, input logic p, input logic t);
      @(negedge clk);
      edge_key  = k;
      pause     = p;
      game_tick = t;
      model_step(k, p, t);
      push_exp();
      @(posedge clk);
      #1;
      edge_key  = 4'd0;
      pause     = 1'b0;
      game_tick = 1'b0;
      sb_pop(tag);
   endtask

   task automatic ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) cycle(tag, 4'd0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      push_exp();
      sb_pop("reset");
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      n_vec     = 0;
      n_bad     = 0;
      rst       = 1'b0;
      edge_key  = 4'd0;
      pause     = 1'b0;
      game_tick = 1'b0;
      model_reset();

      do_reset();

      // IDLE ignores pause and tick
      cycle("idle_ign", 4'd0, 1'b1, 1'b1);

      // Start moving right, three ticks
      cycle("start_r", 4'b1000, 1'b0, 1'b0);
      check("t1.state", 16'(game_state), 16'd1);
      check("t1.dir",   16'(direction),  16'd1);
      ticks("t1.tick", 3);
      check("t1.x",     playerX, 16'd325);
      check("t1.y",     playerY, 16'd230);
      check("t1.score", score,   16'd3);

      // Reverse key rejected, then a turn down
      cycle("rev_l", 4'b0001, 1'b0, 1'b0);
      check("t2.dir_kept", 16'(direction), 16'd1);
      ticks("t2.tick_r", 1);
      check("t2.x", playerX, 16'd330);
      cycle("key_d", 4'b0100, 1'b0, 1'b0);
      ticks("t2.tick_d", 1);
      check("t2.dir", 16'(direction), 16'd2);
      check("t2.y",   playerY,        16'd235);

      // Multi-key priority: all keys while moving down -> R wins
      cycle("all_keys", 4'b1111, 1'b0, 1'b0);
      ticks("prio.tick", 1);
      check("prio.dir", 16'(direction), 16'd1);
      check("prio.x",   playerX,        16'd335);
      // U+L while moving R -> L wins and is rejected
      cycle("ul_keys", 4'b0011, 1'b0, 1'b0);
      ticks("prio2.tick", 1);
      check("prio2.x", playerX, 16'd340);

      // Key in the same cycle as a tick takes effect one tick later
      cycle("u_with_tick", 4'b0010, 1'b0, 1'b1);
      check("t4.x",   playerX,        16'd345);
      check("t4.dir", 16'(direction), 16'd1);
      ticks("t4.tick", 1);
      check("t4.y",   playerY,        16'd230);
      check("t4.dir2",16'(direction), 16'd4);

      // Pause together with a tick: pause wins, no move
      cycle("pause_tick", 4'd0, 1'b1, 1'b1);
      check("t5.state", 16'(game_state), 16'd2);
      check("t5.y",     playerY,         16'd230);
      for (int i = 0; i < 10; i++) begin
         cycle("paused", 4'($urandom_range(0, 15)), 1'b0, 1'b1);
      end
      check("t5.frozen_y", playerY, 16'd230);
      cycle("resume", 4'd0, 1'b1, 1'b0);
      check("t5.resume", 16'(game_state), 16'd1);
      ticks("t5.tick", 1);
      check("t5.moved_y", playerY, 16'd225);

      // Right-wall collision from a fresh game
      do_reset();
      cycle("start_r3", 4'b1000, 1'b0, 1'b0);
      ticks("t3.run", 62);
      check("t3.x",     playerX, 16'd620);
      check("t3.score", score,   16'd62);
      ticks("t3.hit", 1);
      check("t3.hit_x",  playerX,         16'd620);
      check("t3.dead",   16'(game_state), 16'd3);
      cycle("dead_keys", 4'b1111, 1'b1, 1'b0);
      ticks("t3.hold", 49);
      check("t3.hold49", 16'(game_state), 16'd3);
      ticks("t3.hold", 1);
      check("t3.idle",  16'(game_state), 16'd0);
      check("t3.x310",  playerX,         16'd310);
      check("t3.dir0",  16'(direction),  16'd0);
      check("t3.keep",  score,           16'd62);

      // Top-wall collision: stepping up from y=0 must not wrap
      cycle("start_u", 4'b0010, 1'b0, 1'b0);
      check("up.score0", score, 16'd0);
      ticks("up.run", 46);
      check("up.y0", playerY, 16'd0);
      ticks("up.hit", 1);
      check("up.dead", 16'(game_state), 16'd3);
      check("up.y",    playerY,         16'd0);
      ticks("up.hold", 20);

      // Asynchronous reset mid-DEAD, away from the clock edge
      @(posedge clk);
      #3;
      rst = 1'b0;
      model_reset();
      push_exp();
      #1;
      sb_pop("async_rst");
      @(negedge clk);
      rst = 1'b1;
      cycle("after_rst", 4'd0, 1'b0, 1'b1);
      check("t6.state", 16'(game_state), 16'd0);
      check("t6.x",     playerX,         16'd310);
      check("t6.y",     playerY,         16'd230);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Absolute time bound in case the sequence above ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/game_controller.md
Name: game_controller

Overview:
- Single-clock sequencer for the player-movement datapath that feeds the image renderer.
- Accepts one-cycle key-edge pulses from the key filter and a one-cycle game-tick strobe in the same clock domain, which replaces a divided game clock.
- Arbitrates direction changes with a no-reverse rule and steps the player position once per tick.
- Detects wall collisions and runs the game-state FSM (idle / playing / paused / dead), driving game_state, player position and score to the renderer.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
PLAYER_SIZE, 20, player square side in pixels
STEP, 5, pixels moved per tick
START_X, 310, x position on reset/idle
START_Y, 230, y position on reset/idle
DEAD_HOLD, 50, ticks spent in DEAD before returning to IDLE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
edge_key  in  4  one-cycle key pulses; [3]=R, [2]=D, [1]=U, [0]=L
pause  in  1  one-cycle pause/resume pulse
game_tick  in  1  one-cycle movement strobe
game_state  out  4  0=IDLE, 1=PLAYING, 2=PAUSED, 3=DEAD
direction  out  4  committed direction; 0=none, 1=R, 2=D, 4=U, 8=L
playerX  out  16  player left edge, pixels
playerY  out  16  player top edge, pixels
score  out  16  ticks survived, saturating

Behaviour:
- Reset (rst low, asynchronous):
  - game_state=0, direction=0, pending direction=0.
  - playerX=START_X, playerY=START_Y, score=0, hold counter=0.
- All outputs are registered. Coordinate convention: x increases rightward, y increases downward.
- Key arbitration:
  - When several edge_key bits are set in one cycle, priority is R > D > L > U. Only the winner is considered.
  - Reference direction ("ref") = pending direction if game_tick is also high this cycle, otherwise committed direction.
  - The winner is rejected if it is the exact opposite of ref (R/L, U/D). Otherwise it is written to the pending direction.
  - A key matching ref is accepted (no effect).
- IDLE:
  - Position is held at START.
  - Any edge_key → PLAYING next cycle. The winning key is loaded into both committed and pending direction (no reverse check) and score is cleared to 0.
  - pause and game_tick are ignored.
- PLAYING, on game_tick:
  - Commit: direction ← pending.
  - Compute the next position from the committed value, stepping by STEP.
  - Legal range: 0 ≤ x ≤ SCREEN_W−PLAYER_SIZE, 0 ≤ y ≤ SCREEN_H−PLAYER_SIZE.
  - Evaluate in signed 17-bit so moving left/up from below STEP is detected as negative rather than wrapping.
  - If the next position is legal: update the position; score ← score+1, saturating at 16'hFFFF.
  - If illegal: position is unchanged, score is unchanged, → DEAD, hold counter=0.
- PLAYING, pause pulse → PAUSED. If pause and game_tick occur in the same cycle, pause wins and no move happens.
- PAUSED:
  - Ticks and keys are ignored; position, direction and pending are frozen.
  - A pause pulse → PLAYING.
- DEAD:
  - Keys and pause are ignored.
  - Each game_tick increments the hold counter. On the tick where the counter reaches DEAD_HOLD−1 → IDLE.
  - On that transition: position ← START, direction ← 0, pending ← 0. score is retained until the next IDLE→PLAYING.
- Latency: a key accepted in cycle n affects movement at the first game_tick after n. A key accepted in the same cycle as a tick takes effect at the following tick.
- Reset asserted mid-operation returns every output to its reset value immediately. On release the FSM is in IDLE.

Test Plan:
1. Reset, then edge_key=4'b1000 for one cycle → game_state=1, direction=1, score=0. After 3 ticks: playerX=325, playerY=230, score=3.
2. Moving R, pulse L (edge_key=4'b0001) → rejected; direction stays 1. Pulse D then tick → direction=2, playerY=235.
3. Collision: start R, apply 62 ticks → playerX=620, score=62. 63rd tick → playerX stays 620, game_state=3. 50 further ticks → game_state=0, playerX=310, direction=0, score=62.
4. Same-cycle events while moving R with pending=R: pulse U together with a tick → tick moves R (x+5), pending=U; next tick moves U (y−5).
5. Pause: pulse pause → state 2; 10 ticks plus key pulses leave position and direction unchanged. Pulse pause → state 1, and movement resumes on the next tick.
6. Assert rst low mid-DEAD at an arbitrary cycle (not clk-aligned) → outputs immediately at reset values. Release → IDLE, playerX=310, playerY=230.
